hamming_dec_engine: RTL

- Memory-mapped SECDED decode accelerator, downstream consumer of the program-1 Hamming encoder output.
- Walks NUM_WORDS 16-bit codewords stored as byte pairs in data memory.
- Per word: corrects any single-bit error, flags double-bit errors, writes the 11-bit message plus a 2-bit status back to memory.
- Shares the data-memory port with the core while the core is stalled; start/done handshake matches the program interface.

---
 rtl/hamming_dec_engine.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/hamming_dec_engine.sv
// SECDED decode engine: walks NUM_WORDS codewords in data memory, writes message + status back.
// Optional error counters (sgl_cnt/dbl_cnt) enabled by defining HAMMING_DEC_ERR_COUNT_EN.
module hamming_dec_engine #(
   parameter int NUM_WORDS = 15,
   parameter int IN_BASE   = 30,
   parameter int OUT_BASE  = 0,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              done,
`ifdef HAMMING_DEC_ERR_COUNT_EN
   output logic [7:0]        sgl_cnt,
   output logic [7:0]        dbl_cnt,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rd_data,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_data
);

   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE} state_t;

   state_t            state, state_next;
   logic              start_q;
   logic              launch;
   logic [IDX_W-1:0]  idx, idx_next;
   logic [7:0]        lo_byte, hi_byte;
   logic [1:0]        status_reg;
   logic [2:0]        data_hi_reg;
   logic [ADDR_W-1:0] addr_next;
   logic              wr_en_next;
   logic [7:0]        wr_data_next;
   logic              done_next;

   logic [15:0]       codeword;
   logic [3:0]        syndrome;
   logic              parity;
   logic [10:0]       dec_data;
   logic [1:0]        dec_status;

   function automatic logic [ADDR_W-1:0] word_addr(input int base, input logic [IDX_W-1:0] w,
                                                   input logic hi);
      return ADDR_W'(base + 2 * int'(w) + int'(hi));
   endfunction

   // Hamming index of data bit d(i+1); parity bits sit at 1, 2, 4, 8.
   function automatic int data_pos(input int i);
      if (i == 0)
         return 3;
      else if (i < 4)
         return i + 4;
      else
         return i + 5;
   endfunction

   assign launch = ((state == IDLE) || (state == DONE)) && start_q && !start;

   // A single error at a data position is corrected in place; flips of parity bits need no action.
   always_comb begin
      codeword = {hi_byte, lo_byte};
      syndrome = 4'd0;
      for (int k = 1; k < 16; k++) begin
         if (codeword[k])
            syndrome = syndrome ^ 4'(k);
      end
      parity = ^codeword;
      for (int i = 0; i < 11; i++) begin
         dec_data[i] = codeword[data_pos(i)] ^ (parity && (syndrome == 4'(data_pos(i))));
      end
      if (parity)
         dec_status = 2'b01;
      else if (syndrome != 4'd0)
         dec_status = 2'b10;
      else
         dec_status = 2'b00;
   end

   always_comb begin
      state_next   = state;
      idx_next     = idx;
      addr_next    = mem_addr;
      wr_en_next   = 1'b0;
      wr_data_next = mem_wr_data;
      done_next    = done;
      case (state)
         IDLE, DONE: begin
            if (launch) begin
               state_next = RD_LO;
               idx_next   = '0;
               addr_next  = word_addr(IN_BASE, '0, 1'b0);
               done_next  = 1'b0;
            end
         end
         RD_LO: begin
            state_next = RD_HI;
            addr_next  = word_addr(IN_BASE, idx, 1'b1);
         end
         RD_HI: begin
            state_next = DECODE;
         end
         DECODE: begin
            state_next   = WR_LO;
            addr_next    = word_addr(OUT_BASE, idx, 1'b0);
            wr_en_next   = 1'b1;
            wr_data_next = dec_data[7:0];
         end
         WR_LO: begin
            state_next   = WR_HI;
            addr_next    = word_addr(OUT_BASE, idx, 1'b1);
            wr_en_next   = 1'b1;
            wr_data_next = {status_reg, 3'b000, data_hi_reg};
         end
         WR_HI: begin
            if (idx == LAST_IDX) begin
               state_next = DONE;
               done_next  = 1'b1;
            end else begin
               state_next = RD_LO;
               idx_next   = idx + IDX_W'(1);
               addr_next  = word_addr(IN_BASE, idx + IDX_W'(1), 1'b0);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are registered one state ahead so each state presents its address/strobe for the whole cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         start_q     <= 1'b0;
         idx         <= '0;
         lo_byte     <= 8'd0;
         hi_byte     <= 8'd0;
         status_reg  <= 2'b00;
         data_hi_reg <= 3'd0;
         mem_addr    <= '0;
         mem_wr_en   <= 1'b0;
         mem_wr_data <= 8'd0;
         done        <= 1'b0;
      end else begin
         state       <= state_next;
         start_q     <= start;
         idx         <= idx_next;
         mem_addr    <= addr_next;
         mem_wr_en   <= wr_en_next;
         mem_wr_data <= wr_data_next;
         done        <= done_next;
         if (state == RD_LO)
            lo_byte <= mem_rd_data;
         if (state == RD_HI)
            hi_byte <= mem_rd_data;
         if (state == DECODE) begin
            status_reg  <= dec_status;
            data_hi_reg <= dec_data[10:8];
         end
      end
   end

`ifdef HAMMING_DEC_ERR_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset || launch) begin
         sgl_cnt <= 8'd0;
         dbl_cnt <= 8'd0;
      end else if (state == DECODE) begin
         if ((dec_status == 2'b01) && (sgl_cnt != 8'hFF))
            sgl_cnt <= sgl_cnt + 8'd1;
         if ((dec_status == 2'b10) && (dbl_cnt != 8'hFF))
            dbl_cnt <= dbl_cnt + 8'd1;
      end
   end
`endif

endmodule
